// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the RV32I load/store width codes and the responder FSM state type.
package mem_pkg;

    // funct3 width codes used by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for byte/halfword/word accesses to a
// little-endian 32-bit word.
// Ports:
//   funct3     in  3   width code
//   addr_lo    in  2   low address bits (byte lane)
//   word       in  32  word currently stored in the array
//   wdata      in  32  right-aligned store data
//   load_data  out 32  selected lane, sign/zero-extended as funct3 asks
//   byte_en    out 4   lanes written by a store
//   store_data out 32  store data replicated into every lane
//   misalign   out 1   halfword/word access not naturally aligned
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data  = 32'h0;
        byte_en    = 4'b0000;
        store_data = wdata;
        misalign   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                load_data  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'h0, byte_sel};
                byte_en    = 4'b0001 << addr_lo;
                store_data = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                load_data  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            F3_W: begin
                load_data  = word;
                byte_en    = 4'b1111;
                misalign   = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, commits the access to a
// little-endian word array and presents the response until it is taken.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready/req_we/req_addr/req_funct3/req_wdata  request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                     response channel
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam int          ADDR_W = IDX_W + 2;
    localparam logic [31:0] BYTES  = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept, commit;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the commit happens on the accepting edge, so the
    // access is evaluated from the live request inputs while in IDLE.
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata, offset, word, load_data, store_data;
    logic [2:0]  cur_funct3;
    logic [IDX_W-1:0] idx;
    logic [3:0]  byte_en;
    logic        misalign, illegal, out_of_range, err;

    assign cur_we     = (state_reg == IDLE) ? req_we     : we_reg;
    assign cur_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
    assign cur_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
    assign cur_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;

    // Addresses below the base wrap to a huge offset and fault as out of range.
    assign offset       = cur_addr - BASE_ADDR;
    assign out_of_range = (offset >= BYTES);
    assign idx          = offset[ADDR_W-1:2];
    assign word         = mem[idx];

    always_comb begin
        if (cur_we)
            illegal = !(cur_funct3 inside {F3_B, F3_H, F3_W});
        else
            illegal = !(cur_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    assign err = out_of_range | misalign | illegal;

    mem_lane_align u_align (
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .word       (word),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_data (store_data),
        .misalign   (misalign)
    );

    // Next-state logic; commit is suppressed while reset is asserted so an
    // interrupted store never reaches the array.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!reset) begin
            accept = 1'b0;
            commit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            we_reg     <= 1'b0;
            addr_reg   <= 32'h0;
            funct3_reg <= 3'b000;
            wdata_reg  <= 32'h0;
            rdata_reg  <= 32'h0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg     <= req_we;
                addr_reg   <= req_addr;
                funct3_reg <= req_funct3;
                wdata_reg  <= req_wdata;
            end
            if (commit) begin
                rdata_reg <= (err || cur_we) ? 32'h0 : load_data;
                err_reg   <= err;
            end else if (state_reg == RESP && rsp_ready) begin
                rdata_reg <= 32'h0;
                err_reg   <= 1'b0;
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[idx][i*8 +: 8] <= store_data[i*8 +: 8];
            end
        end
    end

    assign req_ready = (state_reg == IDLE) && reset;
    assign rsp_valid = (state_reg == RESP) && reset;
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule
